// File: rtl/mo_picture_shifter.sv
// Motion-object picture shifter: buffers one 8-pixel, 4-plane graphics group in a hold
// register and serialises it, one pixel per pix_en edge, onto the line-buffer MOSR bus.
module mo_picture_shifter (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        gld_b,
  input  logic [31:0] grd,
  input  logic        mohflip,
  input  logic [2:0]  color,
  input  logic        flush,
  output logic [6:0]  mosr,
  output logic        mo_opaque,
  output logic        overrun
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [6:0] MOSR_IDLE = 7'b000_1111;

  state_t          state_reg, state_next;
  logic [31:0]     hold_grd_reg;
  logic            hold_flip_reg;
  logic [2:0]      hold_color_reg;
  logic            pending_reg;
  logic [3:0][7:0] plane_reg, plane_next;
  logic            flip_reg, flip_next;
  logic [2:0]      color_reg, color_next;
  logic [2:0]      count_reg;
  logic            overrun_reg;
  logic [6:0]      mosr_reg, mosr_next;
  logic            opaque_reg;
  logic [3:0]      pixel_next;

  logic capture, transfer, shift;

  assign capture  = pix_en & ~gld_b;
  // Transfer decisions see the registered pending flag, never a same-edge capture.
  assign transfer = pix_en & pending_reg & ((state_reg == IDLE) | (count_reg == 3'd7));
  assign shift    = pix_en & (state_reg == ACTIVE) & (count_reg != 3'd7);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else if (flush) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (pix_en) begin
      case (state_reg)
        IDLE:    if (pending_reg) state_next = ACTIVE;
        ACTIVE:  if (count_reg == 3'd7 && !pending_reg) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_plane
      assign plane_next[gi] = transfer ? hold_grd_reg[gi*8 +: 8] :
                              shift    ? (flip_reg ? (plane_reg[gi] >> 1) : (plane_reg[gi] << 1)) :
                                         plane_reg[gi];
      assign pixel_next[gi] = flip_next ? plane_next[gi][0] : plane_next[gi][7];
    end
  endgenerate

  assign flip_next  = transfer ? hold_flip_reg  : flip_reg;
  assign color_next = transfer ? hold_color_reg : color_reg;

  // Output logic: precompute what the shifter will present after this edge so mosr is a register.
  always_comb begin
    mosr_next = MOSR_IDLE;
    if (!flush && state_next == ACTIVE) begin
      mosr_next = {color_next, pixel_next};
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_grd_reg   <= '0;
      hold_flip_reg  <= 1'b0;
      hold_color_reg <= '0;
      pending_reg    <= 1'b0;
      plane_reg      <= '0;
      flip_reg       <= 1'b0;
      color_reg      <= '0;
      count_reg      <= '0;
      overrun_reg    <= 1'b0;
      mosr_reg       <= MOSR_IDLE;
      opaque_reg     <= 1'b0;
    end else if (flush) begin
      pending_reg    <= 1'b0;
      count_reg      <= '0;
      mosr_reg       <= MOSR_IDLE;
      opaque_reg     <= 1'b0;
    end else begin
      plane_reg  <= plane_next;
      flip_reg   <= flip_next;
      color_reg  <= color_next;
      mosr_reg   <= mosr_next;
      opaque_reg <= (mosr_next[3:0] != 4'hF);
      if (transfer) begin
        count_reg <= '0;
      end else if (shift) begin
        count_reg <= count_reg + 3'd1;
      end
      if (capture) begin
        hold_grd_reg   <= grd;
        hold_flip_reg  <= mohflip;
        hold_color_reg <= color;
        pending_reg    <= 1'b1;
        if (pending_reg) overrun_reg <= 1'b1;
      end else if (transfer) begin
        pending_reg <= 1'b0;
      end
    end
  end

  assign mosr      = mosr_reg;
  assign mo_opaque = opaque_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_mo_picture_shifter.sv
// Scoreboard bench for mo_picture_shifter: a pixel-level object model predicts mosr, mo_opaque
// and overrun after every clock edge; a separate monitor compares the DUT against those predictions.
module tb_mo_picture_shifter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pix_en = 1'b0;
  logic        gld_b = 1'b1;
  logic [31:0] grd = '0;
  logic        mohflip = 1'b0;
  logic [2:0]  color = '0;
  logic        flush = 1'b0;
  logic [6:0]  mosr;
  logic        mo_opaque;
  logic        overrun;

  mo_picture_shifter dut (
    .clk       (clk),
    .reset     (reset),
    .pix_en    (pix_en),
    .gld_b     (gld_b),
    .grd       (grd),
    .mohflip   (mohflip),
    .color     (color),
    .flush     (flush),
    .mosr      (mosr),
    .mo_opaque (mo_opaque),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] mosr;
    logic       opq;
    logic       ovr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;

  // Reference model: an object is a list of 8 pixels plus a colour.
  bit         m_active;
  int         m_idx;
  bit         m_pend;
  bit         m_ovr;
  logic [31:0] m_hold_grd;
  bit         m_hold_flip;
  logic [2:0] m_hold_col;
  logic [3:0] m_pix [8];
  logic [2:0] m_col;

  function automatic logic [3:0] obj_pixel(input logic [31:0] g, input bit f, input int i);
    logic [3:0] p;
    for (int pl = 0; pl < 4; pl++) p[pl] = f ? g[pl*8 + i] : g[pl*8 + 7 - i];
    return p;
  endfunction

  task automatic model_edge(input bit rst_n, input bit pe, input bit gld, input logic [31:0] g,
                            input bit f, input logic [2:0] c, input bit fl);
    exp_t e;
    bit   old_pend;
    if (!rst_n) begin
      m_active = 0; m_idx = 0; m_pend = 0; m_ovr = 0;
      m_hold_grd = '0; m_hold_flip = 0; m_hold_col = '0;
    end else if (fl) begin
      m_active = 0; m_idx = 0; m_pend = 0;
    end else if (pe) begin
      old_pend = m_pend;
      if (m_active && m_idx < 7) begin
        m_idx++;
      end else if (old_pend) begin
        for (int i = 0; i < 8; i++) m_pix[i] = obj_pixel(m_hold_grd, m_hold_flip, i);
        m_col = m_hold_col;
        m_idx = 0;
        m_active = 1;
        m_pend = 0;
      end else begin
        m_active = 0;
      end
      if (!gld) begin
        if (old_pend) m_ovr = 1;
        m_hold_grd = g; m_hold_flip = f; m_hold_col = c;
        m_pend = 1;
      end
    end
    e.mosr = m_active ? {m_col, m_pix[m_idx]} : 7'h0F;
    e.opq  = (e.mosr[3:0] != 4'hF);
    e.ovr  = m_ovr;
    exp_q.push_back(e);
  endtask

  task automatic step(input bit rst_n, input bit pe, input bit gld, input logic [31:0] g,
                      input bit f, input logic [2:0] c, input bit fl);
    @(negedge clk);
    reset = rst_n; pix_en = pe; gld_b = gld; grd = g; mohflip = f; color = c; flush = fl;
    model_edge(rst_n, pe, gld, g, f, c, fl);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(0, $urandom_range(0, 1), 1, '0, 0, '0, 0);
  endtask

  task automatic load(input logic [31:0] g, input bit f, input logic [2:0] c);
    step(1, 1, 0, g, f, c, 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 1, $urandom, $urandom_range(0, 1), 3'($urandom), 0);
  endtask

  // Monitor: the DUT presents a fresh output after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (mosr !== e.mosr) begin
          failures++;
          $display("FAIL mosr cycle=%0d got=%h expected=%h", cycle, mosr, e.mosr);
        end
        checks++;
        if (mo_opaque !== e.opq) begin
          failures++;
          $display("FAIL mo_opaque cycle=%0d got=%b expected=%b", cycle, mo_opaque, e.opq);
        end
        checks++;
        if (overrun !== e.ovr) begin
          failures++;
          $display("FAIL overrun cycle=%0d got=%b expected=%b", cycle, overrun, e.ovr);
        end
        $display("cycle=%0d mosr=%h opaque=%b overrun=%b", cycle, mosr, mo_opaque, overrun);
      end
    end
  end

  initial begin
    do_reset(3);
    // Single load, colour 5
    load(32'hFF00_FF00, 0, 3'd5); run(10);
    // Flip orientation on a lone plane-0 bit
    load(32'h0000_0001, 1, 3'd3); run(10);
    load(32'h0000_0001, 0, 3'd3); run(10);
    // Back-to-back: second load while first group is at count 3
    load(32'h1234_5678, 0, 3'd2); run(4);
    load(32'h8765_4321, 1, 3'd6); run(14);
    // Overrun: two loads with no transfer between them
    load(32'hAAAA_5555, 0, 3'd1); load(32'h0F0F_F0F0, 0, 3'd7); run(20);
    do_reset(1);
    // Load landing exactly on count 7 with nothing pending
    load(32'hC3C3_3C3C, 0, 3'd4); run(8);
    load(32'h00FF_00FF, 1, 3'd2); run(10);
    // Flush at count 4, including a pending load
    load(32'hFFFF_0000, 0, 3'd3); run(5);
    load(32'h1111_2222, 0, 3'd1);
    step(1, 1, 1, '0, 0, '0, 1); run(4);
    step(1, 0, 1, '0, 0, '0, 1); run(3);
    // Reset in the middle of a group
    load(32'hDEAD_BEEF, 0, 3'd6); run(3);
    do_reset(1); run(10);
    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 9) != 0), $urandom, $urandom_range(0, 1),
           3'($urandom), ($urandom_range(0, 99) == 0));
    end
    @(negedge clk);
    pix_en = 0; gld_b = 1; flush = 0; reset = 1;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
